load_store_unit: RTL and testbench

//   Memory-stage load/store unit between the EX/MEM pipeline register and data memory.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/load_store_unit_if.sv | 38 +++
 rtl/load_align.sv | 32 +++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 tb/tb_load_store_unit.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM states and access-legality helpers for the load/store unit.
// Purely declarative; no logic of its own.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        if (is_store) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else          ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                           (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

    // Size lives in funct3[1:0]; the sign bit does not affect alignment.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (f3[1:0] == 2'b01) mis = off[0];
        if (f3[1:0] == 2'b10) mis = (off != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and data-memory bus of the load/store unit.
// slave = the LSU; master = the pipeline plus memory that surround it.
interface load_store_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] store_data;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] load_data;
    logic            misaligned;
    logic            fault;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ready;

    modport slave (
        input  req_valid, mem_read, mem_write, funct3, addr, store_data,
        input  dmem_rdata, dmem_ready,
        output stall, done, load_data, misaligned, fault,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be
    );

    modport master (
        output req_valid, mem_read, mem_write, funct3, addr, store_data,
        output dmem_rdata, dmem_ready,
        input  stall, done, load_data, misaligned, fault,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be
    );
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
// Combinational; unknown funct3 yields zero.
module load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);
    logic [XLEN-1:0] w_shifted;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    assign w_shifted = i_rdata >> {i_off, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_B:    o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_H:    o_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   o_data = {{(XLEN-16){1'b0}}, w_half};
            F3_W:    o_data = i_rdata;
            default: o_data = '0;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one handshaked word access per request, stalling the pipe meanwhile.
// Done pulses >=2 cycles after accept (1 on an access error); a silent memory faults after TIMEOUT_CYCLES.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    localparam int              CW      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e      r_state, w_state_nxt;
    logic [XLEN-1:0] r_addr;
    logic [2:0]      r_funct3;
    logic            r_we;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_load_data;
    logic            r_misaligned;
    logic            r_fault;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_fault_in;
    logic            w_mis_in;
    logic            w_timeout;
    logic [XLEN-1:0] w_lanes;
    logic [XLEN-1:0] w_align;
    logic [3:0]      w_be;

    assign w_accept   = ~reset && (r_state == IDLE) && bus.req_valid &&
                        (bus.mem_read || bus.mem_write);
    assign w_fault_in = (bus.mem_read && bus.mem_write) ||
                        !f3_legal(bus.funct3, bus.mem_write);
    assign w_mis_in   = !w_fault_in && f3_misaligned(bus.funct3, bus.addr[1:0]);
    assign w_timeout  = (r_state == BUSY) && !bus.dmem_ready && (r_cnt == CNT_MAX);

    always_comb begin
        w_lanes = bus.store_data;
        case (bus.funct3[1:0])
            2'b00:   w_lanes = {(XLEN/8){bus.store_data[7:0]}};
            2'b01:   w_lanes = {(XLEN/16){bus.store_data[15:0]}};
            default: w_lanes = bus.store_data;
        endcase
    end

    always_comb begin
        w_be = 4'b1111;
        if (r_we) begin
            case (r_funct3[1:0])
                2'b00:   w_be = 4'b0001 << r_addr[1:0];
                2'b01:   w_be = 4'b0011 << r_addr[1:0];
                default: w_be = 4'b1111;
            endcase
        end
    end

    load_align #(.XLEN(XLEN)) u_align (
        .i_rdata  (bus.dmem_rdata),
        .i_off    (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_align)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        bus.stall      = 1'b0;
        bus.done       = 1'b0;
        bus.load_data  = '0;
        bus.misaligned = 1'b0;
        bus.fault      = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.dmem_we    = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        bus.dmem_be    = 4'b0000;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    bus.stall   = 1'b1;
                    w_state_nxt = (w_fault_in || w_mis_in) ? DONE : BUSY;
                end
            end
            BUSY: begin
                bus.stall      = 1'b1;
                bus.dmem_req   = 1'b1;
                bus.dmem_we    = r_we;
                bus.dmem_addr  = {r_addr[XLEN-1:2], 2'b00};
                bus.dmem_wdata = r_we ? r_wdata : '0;
                bus.dmem_be    = w_be;
                if (bus.dmem_ready || w_timeout) w_state_nxt = DONE;
            end
            DONE: begin
                bus.done       = 1'b1;
                bus.load_data  = r_load_data;
                bus.misaligned = r_misaligned;
                bus.fault      = r_fault;
                w_state_nxt    = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_funct3     <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_load_data  <= '0;
            r_misaligned <= 1'b0;
            r_fault      <= 1'b0;
            r_cnt        <= '0;
        end else if (w_accept) begin
            r_addr       <= bus.addr;
            r_funct3     <= bus.funct3;
            r_we         <= bus.mem_write && !bus.mem_read;
            r_wdata      <= w_lanes;
            r_load_data  <= '0;
            r_misaligned <= w_mis_in;
            r_fault      <= w_fault_in;
            r_cnt        <= '0;
        end else if (r_state == BUSY) begin
            if (bus.dmem_ready) begin
                r_cnt <= '0;
                if (!r_we) r_load_data <= w_align;
            end else if (w_timeout) begin
                r_fault <= 1'b1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: stimulus pushes expected responses to a scoreboard, a negedge monitor pops on done.
// Bus shape, latency and reset behaviour are checked inline by the stimulus process.
module tb_load_store_unit;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [31:0] ld;
        logic        mis;
        logic        flt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    load_store_unit_if #(.XLEN(32)) bus ();

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("mon_unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("mon_load_data", bus.load_data, mon_e.ld);
                chk("mon_misaligned", {31'd0, bus.misaligned}, {31'd0, mon_e.mis});
                chk("mon_fault", {31'd0, bus.fault}, {31'd0, mon_e.flt});
            end
        end
    end

    task automatic run(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                       input int rdy_dly, input logic [31:0] exp_ld, input logic exp_mis,
                       input logic exp_flt, input int exp_lat, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd);
        exp_t e;
        int   lat      = 0;
        int   nb       = 0;
        bit   seen_req = 1'b0;
        bit   got      = 1'b0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.store_data = sd;
        #1;
        chk({nm, "_stall_accept"}, {31'd0, bus.stall}, 32'd1);
        e.ld = exp_ld; e.mis = exp_mis; e.flt = exp_flt;
        sb.push_back(e);
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            if (bus.done === 1'b1) begin
                got = 1'b1;
                lat = k;
                bus.dmem_ready = 1'b0;
                chk({nm, "_done_req_low"}, {31'd0, bus.dmem_req}, 32'd0);
                chk({nm, "_done_we_low"}, {31'd0, bus.dmem_we}, 32'd0);
                chk({nm, "_done_stall_low"}, {31'd0, bus.stall}, 32'd0);
            end else if (bus.dmem_req === 1'b1) begin
                if (!seen_req) begin
                    chk({nm, "_dmem_addr"}, bus.dmem_addr, {a[31:2], 2'b00});
                    chk({nm, "_dmem_be"}, {28'd0, bus.dmem_be}, {28'd0, exp_be});
                    chk({nm, "_dmem_we"}, {31'd0, bus.dmem_we}, {31'd0, wr});
                    chk({nm, "_dmem_wdata"}, bus.dmem_wdata, exp_wd);
                    chk({nm, "_busy_stall"}, {31'd0, bus.stall}, 32'd1);
                    chk({nm, "_busy_ld_zero"}, bus.load_data, 32'd0);
                end
                seen_req = 1'b1;
                if (rdy_dly >= 0 && nb == rdy_dly) begin
                    bus.dmem_ready = 1'b1;
                    bus.dmem_rdata = rdata;
                end else begin
                    bus.dmem_ready = 1'b0;
                    bus.dmem_rdata = 32'h5A5A_5A5A;
                end
                nb++;
            end
        end
        if (!got) chk({nm, "_done_wait_expired"}, 32'd0, 32'd1);
        else      chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_req_seen"}, {31'd0, seen_req}, (exp_lat > 1) ? 32'd1 : 32'd0);
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, {31'd0, bus.done}, 32'd0);
        chk({nm, "_idle_ld_zero"}, bus.load_data, 32'd0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.funct3     = 3'b000;
        bus.addr       = 32'd0;
        bus.store_data = 32'd0;
        bus.dmem_rdata = 32'd0;
        bus.dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("rst_load_data", bus.load_data, 32'd0);
        reset = 1'b0;

        //   name       rd  wr  f3      addr          sd            rdata         dly ld            mis   flt   lat be       wdata
        run("lw",       1, 0, 3'b010, 32'h14, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 1'b0, 2, 4'b1111, 32'h0);
        run("lb",       1, 0, 3'b000, 32'h17, 32'h0, 32'hCAFEBABE, 0, 32'hFFFFFFCA, 1'b0, 1'b0, 2, 4'b1111, 32'h0);
        run("lbu",      1, 0, 3'b100, 32'h17, 32'h0, 32'hCAFEBABE, 2, 32'h000000CA, 1'b0, 1'b0, 4, 4'b1111, 32'h0);
        run("lb_lo",    1, 0, 3'b000, 32'h14, 32'h0, 32'hCAFEBABE, 0, 32'hFFFFFFBE, 1'b0, 1'b0, 2, 4'b1111, 32'h0);
        run("lh_hi",    1, 0, 3'b001, 32'h16, 32'h0, 32'hCAFEBABE, 1, 32'hFFFFCAFE, 1'b0, 1'b0, 3, 4'b1111, 32'h0);
        run("lhu_lo",   1, 0, 3'b101, 32'h14, 32'h0, 32'hCAFEBABE, 0, 32'h0000BABE, 1'b0, 1'b0, 2, 4'b1111, 32'h0);
        run("sb",       0, 1, 3'b000, 32'h1D, 32'hA5, 32'h0,       0, 32'h0,        1'b0, 1'b0, 2, 4'b0010, 32'hA5A5A5A5);
        run("sh",       0, 1, 3'b001, 32'h1E, 32'h1234, 32'h0,     1, 32'h0,        1'b0, 1'b0, 3, 4'b1100, 32'h12341234);
        run("sw",       0, 1, 3'b010, 32'h20, 32'h11223344, 32'h0, 0, 32'h0,        1'b0, 1'b0, 2, 4'b1111, 32'h11223344);
        run("lh_mis",   1, 0, 3'b001, 32'h21, 32'h0, 32'h0,       0, 32'h0,        1'b1, 1'b0, 1, 4'b0000, 32'h0);
        run("lw_mis",   1, 0, 3'b010, 32'h22, 32'h0, 32'h0,       0, 32'h0,        1'b1, 1'b0, 1, 4'b0000, 32'h0);
        run("f3_011",   1, 0, 3'b011, 32'h20, 32'h0, 32'h0,       0, 32'h0,        1'b0, 1'b1, 1, 4'b0000, 32'h0);
        run("sbu_bad",  0, 1, 3'b100, 32'h20, 32'h0, 32'h0,       0, 32'h0,        1'b0, 1'b1, 1, 4'b0000, 32'h0);
        run("rd_wr",    1, 1, 3'b010, 32'h20, 32'h0, 32'h0,       0, 32'h0,        1'b0, 1'b1, 1, 4'b0000, 32'h0);
        run("timeout",  1, 0, 3'b010, 32'h30, 32'h0, 32'h0,      -1, 32'h0,        1'b0, 1'b1, 16, 4'b1111, 32'h0);

        // Reset in the middle of an access must drop the bus and the stall immediately.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.mem_read  = 1'b1;
        bus.funct3    = 3'b010;
        bus.addr      = 32'h40;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_read  = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_req", {31'd0, bus.dmem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_be", {28'd0, bus.dmem_be}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run("post_rst", 1, 0, 3'b010, 32'h44, 32'h0, 32'h01234567, 1, 32'h01234567, 1'b0, 1'b0, 3, 4'b1111, 32'h0);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
